// File: rtl/snax_gemm_block_scheduler_pkg.sv
// Shared types and width helpers for the SNAX GEMM block scheduler.
package snax_gemm_sched_pkg;

  localparam int unsigned RegDataWidthDef = 32;
  localparam int unsigned DimWidthDef     = 8;
  localparam int unsigned AbWidthDef      = 3 * DimWidthDef;
  localparam int unsigned CWidthDef       = 2 * DimWidthDef;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_e;

  // Field order matches the CSR word order: m occupies the lowest word.
  typedef struct packed {
    logic [RegDataWidthDef-1:0] sub_const;
    logic [RegDataWidthDef-1:0] n;
    logic [RegDataWidthDef-1:0] k;
    logic [RegDataWidthDef-1:0] m;
  } gemm_job_t;

  function automatic int unsigned ab_width(input int unsigned dim_width);
    return 3 * dim_width;
  endfunction

  function automatic int unsigned c_width(input int unsigned dim_width);
    return 2 * dim_width;
  endfunction

endpackage

// File: rtl/snax_gemm_block_scheduler_beat_counter.sv
// Per-stream beat counter: counts up to an expected value and flags extra beats.
module snax_gemm_beat_counter #(
  parameter int unsigned CntWidth = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [CntWidth-1:0] expected,
  output logic                reached,
  output logic                overflow
);

  logic [CntWidth-1:0] count;
  logic [CntWidth-1:0] count_next;
  logic                at_limit;

  // reached looks at the post-update value so completion is seen on the last beat.
  always_comb begin
    at_limit   = (count == expected);
    overflow   = enable && at_limit;
    count_next = count;
    if (enable && !at_limit) begin
      count_next = count + CntWidth'(1);
    end
    reached = (count_next == expected);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else begin
      count <= count_next;
    end
  end

endmodule

// File: rtl/snax_gemm_block_scheduler.sv
// Job-level sequencer between the CSR manager and the GEMM shell: launch,
// beat tracking, busy/done/error reporting and a saturating cycle counter.
module snax_gemm_block_scheduler
  import snax_gemm_sched_pkg::*;
#(
  parameter int unsigned RegDataWidth = 32,
  parameter int unsigned DimWidth     = 8,
  parameter int unsigned PerfWidth    = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [3:0][RegDataWidth-1:0] csr_cfg_i,
  input  logic                         csr_cfg_valid_i,
  output logic                         csr_cfg_ready_o,
  output logic [3:0][RegDataWidth-1:0] gemm_cfg_o,
  output logic                         gemm_ctrl_valid_o,
  input  logic                         gemm_ctrl_ready_i,
  input  logic                         a_fire_i,
  input  logic                         b_fire_i,
  input  logic                         c_fire_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [PerfWidth-1:0]         perf_cnt_o
);

  localparam int unsigned AbWidth = ab_width(DimWidth);
  localparam int unsigned CWidth  = c_width(DimWidth);

  sched_state_e        state;
  logic [DimWidth-1:0] m_q;
  logic [DimWidth-1:0] k_q;
  logic [DimWidth-1:0] n_q;
  logic [AbWidth-1:0]  exp_ab;
  logic [CWidth-1:0]   exp_c;

  logic [DimWidth-1:0] m_in;
  logic [DimWidth-1:0] k_in;
  logic [DimWidth-1:0] n_in;
  logic                accept;
  logic                dims_zero;
  logic                in_run;
  logic                perf_sat;
  logic                a_reached, b_reached, c_reached;
  logic                a_ovf, b_ovf, c_ovf;

  always_comb begin
    m_in      = csr_cfg_i[0][DimWidth-1:0];
    k_in      = csr_cfg_i[1][DimWidth-1:0];
    n_in      = csr_cfg_i[2][DimWidth-1:0];
    accept    = (state == ST_IDLE) && csr_cfg_valid_i;
    dims_zero = (m_in == '0) || (k_in == '0) || (n_in == '0);
    in_run    = (state == ST_RUN);
    perf_sat  = &perf_cnt_o;
  end

  snax_gemm_beat_counter #(.CntWidth(AbWidth)) u_a_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (accept),
    .enable   (in_run && a_fire_i),
    .expected (exp_ab),
    .reached  (a_reached),
    .overflow (a_ovf)
  );

  snax_gemm_beat_counter #(.CntWidth(AbWidth)) u_b_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (accept),
    .enable   (in_run && b_fire_i),
    .expected (exp_ab),
    .reached  (b_reached),
    .overflow (b_ovf)
  );

  snax_gemm_beat_counter #(.CntWidth(CWidth)) u_c_cnt (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (accept),
    .enable   (in_run && c_fire_i),
    .expected (exp_c),
    .reached  (c_reached),
    .overflow (c_ovf)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state             <= ST_IDLE;
      csr_cfg_ready_o   <= 1'b1;
      gemm_ctrl_valid_o <= 1'b0;
      gemm_cfg_o        <= '0;
      busy_o            <= 1'b0;
      done_o            <= 1'b0;
      err_o             <= 1'b0;
      perf_cnt_o        <= '0;
      m_q               <= '0;
      k_q               <= '0;
      n_q               <= '0;
      exp_ab            <= '0;
      exp_c             <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (csr_cfg_valid_i) begin
            gemm_cfg_o      <= csr_cfg_i;
            m_q             <= m_in;
            k_q             <= k_in;
            n_q             <= n_in;
            perf_cnt_o      <= '0;
            busy_o          <= 1'b1;
            csr_cfg_ready_o <= 1'b0;
            if (dims_zero) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
              state  <= ST_DONE;
            end else begin
              err_o             <= 1'b0;
              gemm_ctrl_valid_o <= 1'b1;
              state             <= ST_LAUNCH;
            end
          end
        end
        ST_LAUNCH: begin
          // Products settle here so the comparators see stable targets in RUN.
          exp_ab <= AbWidth'(m_q) * AbWidth'(k_q) * AbWidth'(n_q);
          exp_c  <= CWidth'(m_q) * CWidth'(n_q);
          if (!perf_sat) begin
            perf_cnt_o <= perf_cnt_o + PerfWidth'(1);
          end
          if (gemm_ctrl_ready_i) begin
            gemm_ctrl_valid_o <= 1'b0;
            state             <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (!perf_sat) begin
            perf_cnt_o <= perf_cnt_o + PerfWidth'(1);
          end
          if (a_ovf || b_ovf || c_ovf) begin
            err_o <= 1'b1;
          end
          if (a_reached && b_reached && c_reached) begin
            done_o <= 1'b1;
            state  <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_o          <= 1'b0;
          busy_o          <= 1'b0;
          csr_cfg_ready_o <= 1'b1;
          state           <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
